rr_sched: RTL and testbench

//  Round-robin scheduler sharing one output channel among REQ valid/ready requesters.

---
 rtl/rr_sched.sv | 158 +++++++++++++++
 tb/tb_rr_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sched.sv
// Round-robin scheduler: shares one registered output channel among REQ valid/ready requesters.
// Optional locked bursts keep one owner until its last beat or until the hold limit forces a release.
module rr_sched #(
  parameter int REQ      = 8,
  parameter int DATA     = 32,
  parameter int LOCK     = 1,
  parameter int MAX_HOLD = 4,
  parameter int LOG2_REQ = $clog2(REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [REQ-1:0]                 req_valid_i,
  input  logic [REQ-1:0][DATA-1:0]       req_data_i,
  input  logic [REQ-1:0]                 req_last_i,
  output logic [REQ-1:0]                 req_ready_o,
  output logic                           out_valid_o,
  output logic [DATA-1:0]                out_data_o,
  output logic [LOG2_REQ-1:0]            out_id_o,
  output logic                           out_last_o,
  input  logic                           out_ready_i
);

  // state   | meaning
  // S_IDLE  | grant re-chosen every cycle by masked first-one search from ptr
  // S_BURST | grant fixed to owner until its last beat or MAX_HOLD beats
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam int CNT_W     = $clog2(MAX_HOLD + 1);
  localparam bit USE_BURST = (LOCK != 0) && (MAX_HOLD > 1);

  logic [0:0]          state_q, state_d;
  logic [LOG2_REQ-1:0] ptr_q, ptr_d;
  logic [LOG2_REQ-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA-1:0]     out_data_q, out_data_d;
  logic [LOG2_REQ-1:0] out_id_q, out_id_d;
  logic                out_last_q, out_last_d;

  logic [REQ-1:0]      masked;
  logic [LOG2_REQ-1:0] idx_masked, idx_any, grant, rel_ptr;
  logic [CNT_W-1:0]    cnt_inc;
  logic                adv, grant_en, accept, hold_done, last_sel;
  logic [DATA-1:0]     data_sel;

  always_comb begin
    masked = '0;
    for (int i = 0; i < REQ; i++) begin
      masked[i] = req_valid_i[i] && (LOG2_REQ'(i) >= ptr_q);
    end
  end

  // Scanning downward leaves the lowest set index in each result.
  always_comb begin
    idx_masked = '0;
    idx_any    = '0;
    for (int i = REQ - 1; i >= 0; i--) begin
      if (masked[i])      idx_masked = LOG2_REQ'(i);
      if (req_valid_i[i]) idx_any    = LOG2_REQ'(i);
    end
  end

  assign grant    = (state_q == S_BURST) ? owner_q : ((|masked) ? idx_masked : idx_any);
  assign adv      = !out_valid_q || out_ready_i;
  assign grant_en = rst_ni && adv && ((state_q == S_BURST) || (|req_valid_i));

  always_comb begin
    req_ready_o = '0;
    data_sel    = '0;
    last_sel    = 1'b0;
    for (int i = 0; i < REQ; i++) begin
      req_ready_o[i] = grant_en && (grant == LOG2_REQ'(i));
      if (grant == LOG2_REQ'(i)) begin
        data_sel = req_data_i[i];
        last_sel = req_last_i[i];
      end
    end
  end

  assign accept    = |(req_ready_o & req_valid_i);
  assign rel_ptr   = (grant == LOG2_REQ'(REQ - 1)) ? '0 : grant + LOG2_REQ'(1);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign hold_done = (cnt_inc == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (USE_BURST && !last_sel) begin
            state_d = S_BURST;
            owner_d = grant;
            cnt_d   = CNT_W'(1);
          end else begin
            ptr_d = rel_ptr;
          end
        end
        default: begin
          if (last_sel || hold_done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ptr_d   = rel_ptr;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  // A load on the same edge as a drain replaces the held beat without a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = data_sel;
      out_id_d    = grant;
      out_last_d  = last_sel;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_rr_sched.sv
// Bench for rr_sched: directed scenarios plus random traffic against a rotating-search reference model,
// on an 8-requester locked instance and a 5-requester unlocked instance sharing the same stimulus.
module tb_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [7:0]       iv, il;
  logic [7:0][31:0] idat;
  logic             ordy;
  int               sel;

  logic [7:0]  a_rdy;
  logic        a_ov, a_ol;
  logic [31:0] a_od;
  logic [2:0]  a_oid;
  logic [4:0]  b_rdy;
  logic        b_ov, b_ol;
  logic [31:0] b_od;
  logic [2:0]  b_oid;

  logic [7:0]  s_rdy;
  logic        s_ov, s_ol;
  logic [31:0] s_od;
  logic [2:0]  s_oid;

  rr_sched #(.REQ(8), .DATA(32), .LOCK(1), .MAX_HOLD(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(iv), .req_data_i(idat), .req_last_i(il), .req_ready_o(a_rdy),
    .out_valid_o(a_ov), .out_data_o(a_od), .out_id_o(a_oid), .out_last_o(a_ol),
    .out_ready_i(ordy)
  );

  rr_sched #(.REQ(5), .DATA(32), .LOCK(0), .MAX_HOLD(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(iv[4:0]), .req_data_i(idat[4:0]), .req_last_i(il[4:0]), .req_ready_o(b_rdy),
    .out_valid_o(b_ov), .out_data_o(b_od), .out_id_o(b_oid), .out_last_o(b_ol),
    .out_ready_i(ordy)
  );

  always_comb begin
    if (sel == 1) begin
      s_rdy = {3'b000, b_rdy}; s_ov = b_ov; s_od = b_od; s_oid = b_oid; s_ol = b_ol;
    end else begin
      s_rdy = a_rdy; s_ov = a_ov; s_od = a_od; s_oid = a_oid; s_ol = a_ol;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner < 0 means no burst in progress.
  int          m_req, m_lock, m_hold;
  int          m_ptr, m_owner, m_beats, m_oid, m_accg;
  bit          m_ov, m_ol, m_acc;
  logic [31:0] m_od;

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_beats = 0;
    m_ov = 0; m_ol = 0; m_od = '0; m_oid = 0;
    m_acc = 0; m_accg = 0;
  endtask

  function automatic int model_grant(output bit rdy);
    bit adv, found;
    int g;
    adv = !m_ov || ordy;
    g = 0; found = 0;
    if (m_owner >= 0) begin
      g = m_owner;
      rdy = adv;
    end else begin
      for (int k = 0; k < m_req; k++) begin
        int idx;
        idx = (m_ptr + k) % m_req;
        if (!found && iv[idx]) begin g = idx; found = 1; end
      end
      rdy = adv && found;
    end
    return g;
  endfunction

  function automatic logic [7:0] model_ready();
    bit r;
    int g;
    g = model_grant(r);
    return r ? (8'h01 << g) : 8'h00;
  endfunction

  task automatic model_edge();
    bit r;
    int g;
    g = model_grant(r);
    m_acc = r && iv[g];
    m_accg = g;
    if (m_acc) begin
      m_ov = 1; m_od = idat[g]; m_oid = g; m_ol = il[g];
      if (m_owner < 0) begin
        if (m_lock != 0 && !il[g] && m_hold > 1) begin
          m_owner = g; m_beats = 1;
        end else begin
          m_ptr = (g + 1) % m_req;
        end
      end else begin
        m_beats++;
        if (il[g] || m_beats >= m_hold) begin
          m_owner = -1; m_beats = 0; m_ptr = (g + 1) % m_req;
        end
      end
    end else if (ordy) begin
      m_ov = 0;
    end
  endtask

  // One clock: check grant before the edge, advance model on the edge, check outputs on the falling edge.
  task automatic tick();
    #1;
    check_eq("ready", s_rdy, model_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("out_valid", s_ov, m_ov);
    check_eq("out_data", s_od, m_od);
    check_eq("out_id", s_oid, m_oid);
    check_eq("out_last", s_ol, m_ol);
  endtask

  task automatic reset_outputs_zero(input string tag);
    check_eq({tag, "_ov"}, s_ov, 0);
    check_eq({tag, "_od"}, s_od, 0);
    check_eq({tag, "_oid"}, s_oid, 0);
    check_eq({tag, "_ol"}, s_ol, 0);
    check_eq({tag, "_rdy"}, s_rdy, 0);
  endtask

  task automatic random_refresh();
    for (int i = 0; i < m_req; i++) begin
      if (!iv[i] || (m_acc && m_accg == i)) begin
        iv[i]   = ($urandom_range(0, 99) < 55);
        il[i]   = ($urandom_range(0, 2) == 0);
        idat[i] = $urandom;
      end
    end
    ordy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic random_phase(input int n);
    iv = '0; il = '0; ordy = 1'b1;
    for (int k = 0; k < n; k++) begin
      random_refresh();
      tick();
    end
  endtask

  int exp_t4[7] = '{5, 5, 5, 5, 1, 5, 5};

  initial begin
    sel = 0; m_req = 8; m_lock = 1; m_hold = 4;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) idat[i] = 32'hD000_0000 | i;
    iv = 8'hFF; il = 8'hFF; ordy = 1'b1;
    #2 rst_n = 1'b0;

    // reset holds everything at zero even with all requesters valid
    repeat (2) @(negedge clk);
    reset_outputs_zero("t1_rst");
    rst_n = 1'b1;
    model_reset();
    #1 check_eq("t1_rdy", s_rdy, 8'h01);
    tick();
    check_eq("t1_first_id", s_oid, 0);

    // every beat last: rotation 1..7 then wrap to 0
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq("t2_id", s_oid, k % 8);
      check_eq("t2_valid", s_ov, 1);
    end

    // grant 2, then only 0 and 1 valid: pointer 3 wraps
    iv = 8'b0000_0100;
    tick();
    check_eq("t3_id2", s_oid, 2);
    iv = 8'b0000_0011;
    tick();
    check_eq("t3_wrap0", s_oid, 0);
    tick();
    check_eq("t3_then1", s_oid, 1);

    // locked burst from 5 with forced release after 4 beats
    iv = 8'b0010_0010; il = 8'b0000_0010;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq("t4_id", s_oid, exp_t4[k]);
    end

    // backpressure holds the output, then drain and reload on one edge
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t5_rdy", s_rdy, 0);
      check_eq("t5_hold_ov", s_ov, 1);
      check_eq("t5_hold_id", s_oid, 5);
      check_eq("t5_hold_data", s_od, 32'hD000_0005);
    end
    ordy = 1'b1;
    tick();
    check_eq("t5_replace_ov", s_ov, 1);
    check_eq("t5_replace_id", s_oid, 5);

    // reset on the owner's second beat
    iv = 8'b0010_0000;
    tick();
    tick();
    tick();
    check_eq("t6_pre_ov", s_ov, 1);
    iv = 8'b0010_1000;
    rst_n = 1'b0;
    #1 reset_outputs_zero("t6_rst");
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    check_eq("t6_after_id", s_oid, 3);

    random_phase(600);

    // five requesters, unlocked rotation
    @(negedge clk);
    sel = 1; m_req = 5; m_lock = 0; m_hold = 4;
    iv = 8'hFF; il = 8'h00; ordy = 1'b1;
    rst_n = 1'b0;
    #1 reset_outputs_zero("t7_rst");
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      check_eq("t7_id", s_oid, k % 5);
      check_eq("t7_id_range", (s_oid < 3'd5), 1);
    end

    random_phase(600);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
